// File: rtl/square_matmul_stream.sv
`default_nettype none
// ============================================================================
// Module   : square_matmul_stream
// Purpose  : Sequential signed NxN matrix multiplier C = A * B. Loads A/B
//            element pairs over a valid/ready stream, computes with a single
//            MAC per cycle (i outer, j, k inner), then drains C row-major
//            with backpressure.
// Options  : MATMUL_SAT_EN - when defined, C is saturated to DW bits as it
//            is written and out_data is DW wide; otherwise exact OW-bit sums.
// Revision : 1.0 - initial release
// ============================================================================
module square_matmul_stream #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int OW = 2*DW + $clog2(N) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_a,
  input  logic signed [DW-1:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef MATMUL_SAT_EN
  output logic signed [DW-1:0] out_data,
`else
  output logic signed [OW-1:0] out_data,
`endif
  output logic                 out_last,
  output logic                 busy
);

`ifdef MATMUL_SAT_EN
  localparam int CW = DW;
`else
  localparam int CW = OW;
`endif
  localparam int NN = N * N;
  localparam int AW = (NN > 1) ? $clog2(NN) : 1;
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] ADDR_LAST = AW'(NN - 1);
  localparam logic [LW-1:0] LOOP_LAST = LW'(N - 1);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Operand and result storage; deliberately not reset.
  logic signed [DW-1:0] a_mem [NN];
  logic signed [DW-1:0] b_mem [NN];
  logic signed [CW-1:0] c_mem [NN];

  logic [AW-1:0]        load_idx, out_idx;
  logic [LW-1:0]        i_idx, j_idx, k_idx;
  logic signed [OW-1:0] acc;

  logic                   load_fire, out_fire, mac_en, row_end, last_mac;
  logic [AW-1:0]          a_addr, b_addr, c_addr;
  logic signed [2*DW-1:0] product;
  logic signed [OW-1:0]   product_ext, acc_base, mac_sum;
  logic signed [CW-1:0]   c_value;

  assign load_fire = in_valid && (state == LOAD);
  assign out_fire  = out_ready && (state == DRAIN);
  assign mac_en    = (state == COMPUTE);
  assign row_end   = (k_idx == LOOP_LAST);
  assign last_mac  = mac_en && row_end && (j_idx == LOOP_LAST) && (i_idx == LOOP_LAST);

  assign a_addr = AW'(int'(i_idx) * N + int'(k_idx));
  assign b_addr = AW'(int'(k_idx) * N + int'(j_idx));
  assign c_addr = AW'(int'(i_idx) * N + int'(j_idx));

  // Full-width signed product, explicitly sign-extended to the accumulator.
  assign product     = a_mem[a_addr] * b_mem[b_addr];
  assign product_ext = {{(OW-2*DW){product[2*DW-1]}}, product};
  assign acc_base    = (k_idx == '0) ? '0 : acc;
  assign mac_sum     = acc_base + product_ext;

`ifdef MATMUL_SAT_EN
  localparam logic signed [OW-1:0] SAT_MAX = OW'((64'sd1 <<< (DW-1)) - 64'sd1);
  localparam logic signed [OW-1:0] SAT_MIN = ~SAT_MAX;
  // Clamp the finished dot product into the DW-bit signed range.
  always_comb begin
    c_value = mac_sum[DW-1:0];
    if (mac_sum > SAT_MAX)
      c_value = SAT_MAX[DW-1:0];
    else if (mac_sum < SAT_MIN)
      c_value = SAT_MIN[DW-1:0];
  end
`else
  assign c_value = mac_sum;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (load_fire && (load_idx == ADDR_LAST)) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (last_mac) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_fire && (out_idx == ADDR_LAST)) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign out_last = (state == DRAIN) && (out_idx == ADDR_LAST);
  assign out_data = (state == DRAIN) ? c_mem[out_idx] : '0;

  // Load/drain indices, MAC loop counters and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_idx <= '0;
      out_idx  <= '0;
      i_idx    <= '0;
      j_idx    <= '0;
      k_idx    <= '0;
      acc      <= '0;
    end else begin
      if (load_fire)
        load_idx <= (load_idx == ADDR_LAST) ? '0 : load_idx + 1'b1;
      if (out_fire)
        out_idx <= (out_idx == ADDR_LAST) ? '0 : out_idx + 1'b1;
      if (mac_en) begin
        acc <= mac_sum;
        if (row_end) begin
          k_idx <= '0;
          if (j_idx == LOOP_LAST) begin
            j_idx <= '0;
            i_idx <= (i_idx == LOOP_LAST) ? '0 : i_idx + 1'b1;
          end else begin
            j_idx <= j_idx + 1'b1;
          end
        end else begin
          k_idx <= k_idx + 1'b1;
        end
      end
    end
  end

  // Matrix storage writes: operands on load, C on the last k of each dot product.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      a_mem[load_idx] <= in_a;
      b_mem[load_idx] <= in_b;
    end
    if (mac_en && row_end)
      c_mem[c_addr] <= c_value;
  end

endmodule
`default_nettype wire

// File: tb/tb_square_matmul_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_square_matmul_stream
// Purpose  : Self-checking bench for square_matmul_stream (N=2, DW=8 main
//            instance plus an N=1 instance). Expected C comes from a plain
//            dot-product model; honours MATMUL_SAT_EN for saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_square_matmul_stream;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int NN = N * N;
  localparam int OW = 2*DW + $clog2(N) + 1;
  localparam int OW1 = 2*DW + 1;
`ifdef MATMUL_SAT_EN
  localparam int CW  = DW;
  localparam int CW1 = DW;
`else
  localparam int CW  = OW;
  localparam int CW1 = OW1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [DW-1:0] in_a, in_b;
  logic [CW-1:0] out_data;

  logic           one_in_valid, one_in_ready, one_out_valid, one_out_last, one_busy;
  logic [DW-1:0]  one_in_a, one_in_b;
  logic [CW1-1:0] one_out_data;

  int     total = 0;
  int     bad   = 0;
  int     ma [NN];
  int     mb [NN];
  longint exp_c [NN];

  always #5 clk = ~clk;

  square_matmul_stream #(.N(N), .DW(DW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  square_matmul_stream #(.N(1), .DW(DW)) u_dut_one (
    .clk(clk), .rst(rst), .in_valid(one_in_valid), .in_ready(one_in_ready),
    .in_a(one_in_a), .in_b(one_in_b), .out_valid(one_out_valid), .out_ready(1'b1),
    .out_data(one_out_data), .out_last(one_out_last), .busy(one_busy)
  );

  // Single comparison point for the whole bench.
  task automatic check_val(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v);
`ifdef MATMUL_SAT_EN
    longint hi = (64'sd1 <<< (DW-1)) - 1;
    longint lo = -(64'sd1 <<< (DW-1));
    if (v > hi) return hi;
    if (v < lo) return lo;
`endif
    return v;
  endfunction

  // Reference: textbook C[i][j] = sum_k A[i][k]*B[k][j].
  function automatic void build_expected();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        longint s = 0;
        for (int k = 0; k < N; k++)
          s += longint'(ma[i*N+k]) * longint'(mb[k*N+j]);
        exp_c[i*N+j] = sat(s);
      end
  endfunction

  function automatic int rnd_elem();
    return int'($urandom_range(255)) - 128;
  endfunction

  function automatic longint out_s();
    return longint'($signed(out_data));
  endfunction

  // Stream A/B in, with random in_valid gaps; returns just after the last accept edge.
  task automatic load_mats(input int gap_pct);
    for (int b = 0; b < NN; b++) begin
      int t;
      while (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_a = DW'(ma[b]);
      in_b = DW'(mb[b]);
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready) begin
          @(posedge clk); #1;
          break;
        end
        @(posedge clk); #1;
        t++;
        if (t > 200) begin
          check_val("load_timeout", 0, 1);
          break;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // Collect C; mode 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random ready.
  task automatic drain(input int mode);
    int     n = 0, cyc = 0, dcyc = 0, lat = -1;
    bit     stalled = 1'b0;
    longint prev = 0;
    bit     pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    while (n < NN && cyc < 300) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[dcyc % 4];
        default: out_ready = 1'($urandom_range(1));
      endcase
      @(negedge clk);
      cyc++;
      check_val("in_ready_low_busy", in_ready, 0);
      check_val("busy_high", busy, 1);
      if (out_valid) begin
        if (lat < 0) lat = cyc;
        dcyc++;
        if (stalled) check_val("hold_data", out_s(), prev);
        check_val($sformatf("c[%0d]", n), out_s(), exp_c[n]);
        check_val("out_last", out_last, (n == NN-1) ? 1 : 0);
        stalled = !out_ready;
        prev    = out_s();
        if (out_ready) n++;
      end
      @(posedge clk); #1;
    end
    if (n < NN) check_val("drain_timeout", n, NN);
    check_val("latency", lat, N*N*N + 1);
    out_ready = 1'b0;
    check_val("post_in_ready", in_ready, 1);
    check_val("post_out_valid", out_valid, 0);
    check_val("post_busy", busy, 0);
  endtask

  task automatic run_case(input int gap_pct, input int mode);
    build_expected();
    load_mats(gap_pct);
    drain(mode);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int na0, nb0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    one_in_valid = 1'b0; one_in_a = '0; one_in_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_last", out_last, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_out_data", out_s(), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Known 2x2 product: 19,22,43,50.
    ma = '{1, 2, 3, 4}; mb = '{5, 6, 7, 8};
    run_case(0, 0);

    // Identity and negative identity.
    ma = '{1, 0, 0, 1}; mb = '{0, 1, 2, 3};
    run_case(0, 0);
    ma = '{-1, 0, 0, -1};
    run_case(30, 0);

    // Extremes: 127s and -128s.
    ma = '{127, 127, 127, 127}; mb = ma;
    run_case(0, 0);
    ma = '{-128, -128, -128, -128}; mb = ma;
    run_case(0, 0);

    // Backpressure pattern.
    ma = '{1, 2, 3, 4}; mb = '{5, 6, 7, 8};
    run_case(0, 1);

    // Reset during COMPUTE cycle 3, then a fresh load.
    build_expected();
    load_mats(0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_in_ready", in_ready, 1);
    check_val("mid_rst_out_valid", out_valid, 0);
    check_val("mid_rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_case(0, 0);

    // in_valid held high through COMPUTE/DRAIN with next beat 0 presented.
    for (int b = 0; b < NN; b++) begin ma[b] = rnd_elem(); mb[b] = rnd_elem(); end
    build_expected();
    load_mats(40);
    na0 = rnd_elem(); nb0 = rnd_elem();
    in_valid = 1'b1; in_a = DW'(na0); in_b = DW'(nb0);
    drain(0);
    for (int b = 0; b < NN; b++) begin ma[b] = rnd_elem(); mb[b] = rnd_elem(); end
    ma[0] = na0; mb[0] = nb0;
    run_case(0, 0);

    // Randomised matrices with random gaps and random backpressure.
    for (int r = 0; r < 20; r++) begin
      for (int b = 0; b < NN; b++) begin ma[b] = rnd_elem(); mb[b] = rnd_elem(); end
      run_case(25, 2);
    end

    // N=1: one-cycle COMPUTE, out_last on the single beat.
    for (int t = 0; t < 6; t++) begin
      int a1, b1;
      a1 = (t == 0) ? -128 : rnd_elem();
      b1 = (t == 0) ? -128 : rnd_elem();
      one_in_valid = 1'b1; one_in_a = DW'(a1); one_in_b = DW'(b1);
      @(negedge clk);
      check_val("n1_in_ready", one_in_ready, 1);
      @(posedge clk); #1;
      one_in_valid = 1'b0;
      @(negedge clk);
      check_val("n1_compute_valid", one_out_valid, 0);
      check_val("n1_compute_busy", one_busy, 1);
      @(negedge clk);
      check_val("n1_out_valid", one_out_valid, 1);
      check_val("n1_out_data", longint'($signed(one_out_data)), sat(longint'(a1) * longint'(b1)));
      check_val("n1_out_last", one_out_last, 1);
      @(posedge clk); #1;
      check_val("n1_back_to_load", one_in_ready, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
